bram_arb: RTL and testbench

- Two-port arbiter and sequencer for the shared 16-bit block RAM behind MemBus.
- Port A serves the MCU bridge; port B serves the console-side engine.
- Each granted request becomes one word access held for MEM_TIME cycles, then one idle cycle with an ack pulse.
- Requesters see a simple req/ack handshake and never drive the RAM directly.

---
 rtl/bram_arb.sv | 185 ++++++++++++++++++
 tb/tb_bram_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arb.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb
// Purpose  : Two-port arbiter and sequencer for the shared 16-bit block RAM.
//            Port A (MCU bridge) and port B (console engine) each present a
//            level req; a granted request becomes one word access. Address,
//            data and strobes are held for MEM_TIME cycles, then an idle
//            cycle carries a one-cycle ack. Ties go to the port that was not
//            granted last, so grants alternate under continuous contention.
// Ports    : clk, rst_n (async, active low)
//            a_req/a_we/a_addr/a_dati -> a_ack/a_dato   (port A)
//            b_req/b_we/b_addr/b_dati -> b_ack/b_dato   (port B)
//            mem_addr/mem_dati/mem_oe/mem_we -> RAM, mem_dato <- RAM
// Revision : 1.0 - initial release
// ============================================================================
module bram_arb #(
    parameter int MEM_TIME = 2,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic [1:0]    a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_dati,
    output logic          a_ack,
    output logic [15:0]   a_dato,
    input  logic          b_req,
    input  logic [1:0]    b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [15:0]   b_dati,
    output logic          b_ack,
    output logic [15:0]   b_dato,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_dati,
    output logic          mem_oe,
    output logic [1:0]    mem_we,
    input  logic [15:0]   mem_dato
);

    generate
        if (MEM_TIME < 1) begin : g_bad_mem_time
            $error("bram_arb: MEM_TIME must be at least 1");
        end
    endgenerate

    localparam int c_cw = (MEM_TIME > 1) ? $clog2(MEM_TIME) : 1;
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(MEM_TIME - 1);

    // Port identifiers used for r_last / r_gnt
    localparam logic c_port_a = 1'b0;
    localparam logic c_port_b = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              r_gnt;
    logic [1:0]        r_we;
    logic [AW-1:0]     r_addr;
    logic [15:0]       r_dati;
    logic [c_cw-1:0]   r_cnt;
    logic [15:0]       r_a_dato;
    logic [15:0]       r_b_dato;

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_cnt_zero;

    // A wins when B is idle or when B was the last port served.
    always_comb begin
        w_gnt_a    = a_req & (~b_req | (r_last == c_port_b));
        w_gnt_b    = b_req & ~w_gnt_a;
        w_cnt_zero = (r_cnt == '0);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. Strobes decode straight from the state
    // register so an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_oe      = 1'b0;
        mem_we      = 2'b00;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_a || w_gnt_b) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_oe = (r_we == 2'b00);
                mem_we = r_we;
                if (w_cnt_zero) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                a_ack       = (r_gnt == c_port_a);
                b_ack       = (r_gnt == c_port_b);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, access counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= c_port_b;
            r_gnt    <= c_port_a;
            r_we     <= 2'b00;
            r_addr   <= '0;
            r_dati   <= '0;
            r_cnt    <= '0;
            r_a_dato <= '0;
            r_b_dato <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_a) begin
                        r_gnt  <= c_port_a;
                        r_last <= c_port_a;
                        r_we   <= a_we;
                        r_addr <= a_addr;
                        r_dati <= a_dati;
                        r_cnt  <= c_cnt_init;
                    end else if (w_gnt_b) begin
                        r_gnt  <= c_port_b;
                        r_last <= c_port_b;
                        r_we   <= b_we;
                        r_addr <= b_addr;
                        r_dati <= b_dati;
                        r_cnt  <= c_cnt_init;
                    end
                end
                S_ACCESS: begin
                    if (w_cnt_zero) begin
                        // Only the granted port's read register is touched.
                        if (r_we == 2'b00) begin
                            if (r_gnt == c_port_a) begin
                                r_a_dato <= mem_dato;
                            end else begin
                                r_b_dato <= mem_dato;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign mem_dati = r_dati;
    assign a_dato   = r_a_dato;
    assign b_dato   = r_b_dato;

endmodule
`default_nettype wire

// File: tb/tb_bram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_arb
// Purpose  : Self-checking bench for bram_arb. dut0 uses MEM_TIME=2 against a
//            behavioural byte-writable RAM; dut1 uses MEM_TIME=1 against a
//            fixed read pattern. Expected read data comes from a shadow model
//            of the RAM kept by the bench and queued when requests are issued.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // dut0 (MEM_TIME = 2)
    logic        a_req, b_req;
    logic [1:0]  a_we, b_we;
    logic [15:0] a_addr, b_addr, a_dati, b_dati;
    logic        a_ack, b_ack;
    logic [15:0] a_dato, b_dato;
    logic [15:0] mem_addr, mem_dati, mem_dato;
    logic        mem_oe;
    logic [1:0]  mem_we;

    // dut1 (MEM_TIME = 1)
    logic        t1_a_req;
    logic [15:0] t1_a_addr;
    logic        t1_a_ack, t1_b_ack;
    logic [15:0] t1_a_dato, t1_b_dato;
    logic [15:0] t1_mem_addr, t1_mem_dati, t1_mem_dato;
    logic        t1_mem_oe;
    logic [1:0]  t1_mem_we;

    // Behavioural RAM for dut0 plus a preload port for the bench
    logic [15:0] ram [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        if (mem_we[0]) ram[mem_addr[7:0]][7:0]  <= mem_dati[7:0];
        if (mem_we[1]) ram[mem_addr[7:0]][15:8] <= mem_dati[15:8];
    end
    assign mem_dato    = ram[mem_addr[7:0]];
    assign t1_mem_dato = (t1_mem_addr == 16'h0005) ? 16'hC0DE : 16'h0000;

    // Shadow model and scoreboard
    logic [15:0] model [0:255];
    typedef struct packed {
        logic        port;
        logic        rd;
        logic [15:0] data;
    } sb_t;
    sb_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bram_arb #(.MEM_TIME(2), .AW(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_dati(a_dati),
        .a_ack(a_ack), .a_dato(a_dato),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_dati(b_dati),
        .b_ack(b_ack), .b_dato(b_dato),
        .mem_addr(mem_addr), .mem_dati(mem_dati), .mem_oe(mem_oe),
        .mem_we(mem_we), .mem_dato(mem_dato)
    );

    bram_arb #(.MEM_TIME(1), .AW(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(t1_a_req), .a_we(2'b00), .a_addr(t1_a_addr), .a_dati(16'h0000),
        .a_ack(t1_a_ack), .a_dato(t1_a_dato),
        .b_req(1'b0), .b_we(2'b00), .b_addr(16'h0000), .b_dati(16'h0000),
        .b_ack(t1_b_ack), .b_dato(t1_b_dato),
        .mem_addr(t1_mem_addr), .mem_dati(t1_mem_dati), .mem_oe(t1_mem_oe),
        .mem_we(t1_mem_we), .mem_dato(t1_mem_dato)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one access from an IDLE cycle, hold req until its ack, then drop.
    // Reports latency (cycles from req to ack), strobe cycle counts and
    // whether every strobed cycle carried the right address/data/strobes.
    // The scoreboard entry queued at issue is retired at the ack.
    task automatic run_access(input logic port, input logic [1:0] we,
                              input logic [15:0] addr, input logic [15:0] dati,
                              output int lat, output int oe_cyc,
                              output int we_cyc, output bit ok);
        sb_t         e;
        logic [15:0] got;
        tick;
        if (port == 1'b0) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_dati = dati;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_dati = dati;
        end
        e.port = port;
        e.rd   = (we == 2'b00);
        if (we == 2'b00) begin
            e.data = model[addr[7:0]];
        end else begin
            if (we[0]) model[addr[7:0]][7:0]  = dati[7:0];
            if (we[1]) model[addr[7:0]][15:8] = dati[15:8];
            e.data = 16'h0000;
        end
        exp_q.push_back(e);
        lat = -1; oe_cyc = 0; we_cyc = 0; ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (mem_oe) oe_cyc++;
            if (mem_we != 2'b00) we_cyc++;
            if (mem_oe || mem_we != 2'b00) begin
                if (mem_addr !== addr || (mem_oe && mem_we != 2'b00) ||
                    (we != 2'b00 && (mem_we !== we || mem_dati !== dati)))
                    ok = 1'b0;
            end
            if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) begin
                lat = i;
                e   = exp_q.pop_front();
                n_checks++;
                if (a_ack && b_ack) begin
                    n_fail++;
                    $display("FAIL sb_dual_ack: a_ack=%0b b_ack=%0b, required one ack", a_ack, b_ack);
                end
                if (e.rd) begin
                    got = e.port ? b_dato : a_dato;
                    n_checks++;
                    if (got !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_read_data port=%0d addr=%h: got %h, required %h",
                                 e.port, addr, got, e.data);
                    end
                end
                break;
            end
        end
        if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout port=%0d: no ack within 20 cycles", port);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        a_req = 0; a_we = 0; a_addr = 0; a_dati = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_dati = 0;
        t1_a_req = 0; t1_a_addr = 0;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        #3;
        n_checks++; if ({a_ack, b_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b, required 00", {a_ack, b_ack}); end
        n_checks++; if (mem_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mem_oe: got %b, required 0", mem_oe); end
        n_checks++; if (mem_we !== 2'b00) begin n_fail++; $display("FAIL rst_mem_we: got %b, required 00", mem_we); end
        n_checks++; if (mem_addr !== 16'h0 || mem_dati !== 16'h0) begin n_fail++; $display("FAIL rst_mem_bus: addr %h dati %h, required 0 0", mem_addr, mem_dati); end
        n_checks++; if (a_dato !== 16'h0 || b_dato !== 16'h0) begin n_fail++; $display("FAIL rst_dato: a %h b %h, required 0 0", a_dato, b_dato); end
        // Preload RAM while held in reset
        tick; pre_en = 1'b1; pre_addr = 8'h10; pre_data = 16'hBEEF; model[8'h10] = 16'hBEEF;
        tick; pre_addr = 8'h30; pre_data = 16'h1111; model[8'h30] = 16'h1111;
        tick; pre_addr = 8'h31; pre_data = 16'h2222; model[8'h31] = 16'h2222;
        tick; pre_en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        int lat, oe, we; bit ok;
        run_access(1'b0, 2'b00, 16'h0010, 16'h0000, lat, oe, we, ok);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d, required 3", lat); end
        n_checks++; if (oe !== 2 || we !== 0) begin n_fail++; $display("FAIL read_strobes: oe %0d we %0d cycles, required 2 0", oe, we); end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_bus: got bad addr/strobe, required addr 0010 oe only"); end
        n_checks++; if (a_dato !== 16'hBEEF) begin n_fail++; $display("FAIL read_a_dato: got %h, required BEEF", a_dato); end
        n_checks++; if (b_dato !== 16'h0000) begin n_fail++; $display("FAIL read_b_untouched: got %h, required 0000", b_dato); end
    endtask

    task automatic test_byte_write;
        int lat, oe, we; bit ok;
        run_access(1'b1, 2'b11, 16'h0020, 16'h1234, lat, oe, we, ok);
        n_checks++; if (lat !== 3 || we !== 2 || oe !== 0 || !ok) begin n_fail++; $display("FAIL wr_full: lat %0d we %0d oe %0d ok %0b, required 3 2 0 1", lat, we, oe, ok); end
        run_access(1'b1, 2'b10, 16'h0020, 16'hAB55, lat, oe, we, ok);
        n_checks++; if (we !== 2 || !ok) begin n_fail++; $display("FAIL wr_hi_byte: we cycles %0d ok %0b, required 2 1", we, ok); end
        run_access(1'b1, 2'b00, 16'h0020, 16'h0000, lat, oe, we, ok);
        n_checks++; if (b_dato !== 16'hAB34) begin n_fail++; $display("FAIL byte_merge: got %h, required AB34", b_dato); end
        n_checks++; if (a_dato !== 16'hBEEF) begin n_fail++; $display("FAIL a_dato_hold: got %h, required BEEF", a_dato); end
    endtask

    task automatic test_contention;
        logic        order [0:3];
        int          ack_cyc [0:3];
        int          n_ack;
        logic        p;
        logic [15:0] got, exp_d;
        order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1;
        tick;
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 2'b00; a_addr = 16'h0030;
        b_req = 1'b1; b_we = 2'b00; b_addr = 16'h0031;
        tick;
        rst_n = 1'b1;
        n_ack = 0;
        for (int i = 1; i <= 40 && n_ack < 4; i++) begin
            tick;
            if (a_ack || b_ack) begin
                p     = b_ack;
                got   = p ? b_dato : a_dato;
                exp_d = order[n_ack] ? model[8'h31] : model[8'h30];
                n_checks++;
                if (p !== order[n_ack] || (a_ack && b_ack)) begin
                    n_fail++;
                    $display("FAIL grant_order[%0d]: got port %0d, required %0d", n_ack, p, order[n_ack]);
                end
                n_checks++;
                if (got !== exp_d) begin
                    n_fail++;
                    $display("FAIL contention_data[%0d]: got %h, required %h", n_ack, got, exp_d);
                end
                ack_cyc[n_ack] = i;
                n_ack++;
                if (n_ack == 4) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        n_checks++;
        if (n_ack != 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d acks, required 4", n_ack);
        end else begin
            n_checks++; if (ack_cyc[0] != 3) begin n_fail++; $display("FAIL first_ack_cycle: got %0d, required 3", ack_cyc[0]); end
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (ack_cyc[k] - ack_cyc[k-1] != 4) begin
                    n_fail++;
                    $display("FAIL ack_spacing[%0d]: got %0d, required 4", k, ack_cyc[k] - ack_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_withdrawn;
        int oe, acks, ack_at;
        tick;
        a_req = 1'b1; a_we = 2'b00; a_addr = 16'h0010;
        tick;
        oe = mem_oe ? 1 : 0;
        n_checks++; if (mem_oe !== 1'b1) begin n_fail++; $display("FAIL wd_first_access: mem_oe %b, required 1", mem_oe); end
        a_req = 1'b0;
        acks = 0; ack_at = -1;
        for (int i = 2; i <= 12; i++) begin
            tick;
            if (mem_oe) oe++;
            if (a_ack) begin acks++; ack_at = i; end
        end
        n_checks++; if (acks !== 1 || ack_at !== 3) begin n_fail++; $display("FAIL wd_ack: got %0d acks at %0d, required 1 at 3", acks, ack_at); end
        n_checks++; if (oe !== 2) begin n_fail++; $display("FAIL wd_no_regrant: got %0d oe cycles, required 2", oe); end
        n_checks++; if (a_dato !== 16'hBEEF) begin n_fail++; $display("FAIL wd_data: got %h, required BEEF", a_dato); end
    endtask

    task automatic test_reset_mid;
        int lat, oe, we, acks; bit ok;
        tick;
        a_req = 1'b1; a_we = 2'b11; a_addr = 16'h0040; a_dati = 16'h5555;
        tick;
        n_checks++; if (mem_we !== 2'b11) begin n_fail++; $display("FAIL rm_strobe_on: got %b, required 11", mem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 2'b00 || mem_oe !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop: we %b oe %b, required 00 0", mem_we, mem_oe); end
        a_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (a_ack || b_ack) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rm_no_ack: got %0d acks, required 0", acks); end
        rst_n = 1'b1;
        run_access(1'b0, 2'b00, 16'h0010, 16'h0000, lat, oe, we, ok);
        n_checks++; if (lat !== 3 || oe !== 2) begin n_fail++; $display("FAIL rm_recover: lat %0d oe %0d, required 3 2", lat, oe); end
    endtask

    task automatic test_mem_time1;
        int oe, ack_at;
        tick;
        t1_a_req = 1'b1; t1_a_addr = 16'h0005;
        oe = 0; ack_at = -1;
        for (int i = 1; i <= 6; i++) begin
            tick;
            if (t1_mem_oe) oe++;
            if (t1_a_ack && ack_at < 0) begin ack_at = i; t1_a_req = 1'b0; end
        end
        t1_a_req = 1'b0;
        n_checks++; if (oe !== 1) begin n_fail++; $display("FAIL mt1_oe_cycles: got %0d, required 1", oe); end
        n_checks++; if (ack_at !== 2) begin n_fail++; $display("FAIL mt1_ack_cycle: got %0d, required 2", ack_at); end
        n_checks++; if (t1_a_dato !== 16'hC0DE) begin n_fail++; $display("FAIL mt1_data: got %h, required C0DE", t1_a_dato); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_byte_write;
        test_contention;
        test_withdrawn;
        test_reset_mid;
        test_mem_time1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
